time_set_router: RTL



---
 rtl/time_set_pkg.sv | 29 ++
 rtl/time_field_check.sv | 25 ++
 rtl/time_set_router.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-set router: FSM states, error codes,
// default field limits and bank indices.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SEL   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_BOTH  = 2'd3;

    localparam int DEF_LESS_MAX   = 59;
    localparam int DEF_MIDDLE_MAX = 59;
    localparam int DEF_BIG_MAX    = 23;

    localparam int TGT_CLOCK = 0;
    localparam int TGT_ALARM = 1;
    localparam int TGT_CNTDN = 2;

    // True when exactly one bit of the (zero-extended) select is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/time_field_check.sv
// Legality check for one time field against its MAX limit.
// With TIME_SET_BCD_EN the field is packed BCD and is converted before comparing.
module time_field_check #(
    parameter int FIELD_W = 7,
    parameter int MAX     = 59
) (
    input  logic [FIELD_W-1:0] i_field,
    output logic               o_legal
);

`ifdef TIME_SET_BCD_EN
    logic [3:0]         w_ones;
    logic [FIELD_W-5:0] w_tens;
    logic [31:0]        w_bin;

    assign w_ones  = i_field[3:0];
    assign w_tens  = i_field[FIELD_W-1:4];
    assign w_bin   = 32'(w_tens) * 32'd10 + 32'(w_ones);
    // A ones digit above 9 is not a BCD digit, so it fails regardless of MAX.
    assign o_legal = (w_ones <= 4'd9) && (w_bin <= 32'(MAX));
`else
    assign o_legal = (32'(i_field) <= 32'(MAX));
`endif

endmodule

// File: rtl/time_set_router.sv
// Staged, range-checked router of a time triple into one of NUM_TARGETS banks.
// Optional packed-BCD field format is enabled with TIME_SET_BCD_EN.
module time_set_router
    import time_set_pkg::*;
#(
    parameter int NUM_TARGETS = 3,
    parameter int FIELD_W     = 7,
    parameter int LESS_MAX    = DEF_LESS_MAX,
    parameter int MIDDLE_MAX  = DEF_MIDDLE_MAX,
    parameter int BIG_MAX     = DEF_BIG_MAX
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_TARGETS-1:0]         in_sel,
    input  logic [FIELD_W-1:0]             in_less,
    input  logic [FIELD_W-1:0]             in_middle,
    input  logic [FIELD_W-1:0]             in_big,
    output logic [NUM_TARGETS*FIELD_W-1:0] bank_less,
    output logic [NUM_TARGETS*FIELD_W-1:0] bank_middle,
    output logic [NUM_TARGETS*FIELD_W-1:0] bank_big,
    output logic [NUM_TARGETS-1:0]         load_pulse,
    output logic                           err_pulse,
    output logic [1:0]                     err_code,
    output logic                           busy
);

    state_t                   r_state;
    logic [NUM_TARGETS-1:0]   r_sel;
    logic [FIELD_W-1:0]       r_less;
    logic [FIELD_W-1:0]       r_middle;
    logic [FIELD_W-1:0]       r_big;
    logic                     r_sel_ok;
    logic                     r_range_ok;
    logic [NUM_TARGETS-1:0]   r_load;
    logic                     r_err_pulse;
    logic [1:0]               r_err_code;
    logic                     r_busy;
    logic                     r_in_ready;

    logic                     w_less_ok;
    logic                     w_middle_ok;
    logic                     w_big_ok;
    logic                     w_commit;

    time_field_check #(.FIELD_W(FIELD_W), .MAX(LESS_MAX)) u_chk_less (
        .i_field (r_less),
        .o_legal (w_less_ok)
    );

    time_field_check #(.FIELD_W(FIELD_W), .MAX(MIDDLE_MAX)) u_chk_middle (
        .i_field (r_middle),
        .o_legal (w_middle_ok)
    );

    time_field_check #(.FIELD_W(FIELD_W), .MAX(BIG_MAX)) u_chk_big (
        .i_field (r_big),
        .o_legal (w_big_ok)
    );

    assign w_commit = (r_state == ST_COMMIT) && r_sel_ok && r_range_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_less      <= '0;
            r_middle    <= '0;
            r_big       <= '0;
            r_sel_ok    <= 1'b0;
            r_range_ok  <= 1'b0;
            r_load      <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_load      <= '0;
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sel      <= in_sel;
                        r_less     <= in_less;
                        r_middle   <= in_middle;
                        r_big      <= in_big;
                        r_err_code <= ERR_NONE;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_sel_ok   <= is_onehot(32'(r_sel));
                    r_range_ok <= w_less_ok && w_middle_ok && w_big_ok;
                    r_state    <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (r_sel_ok && r_range_ok) begin
                        r_load <= r_sel;
                    end else begin
                        r_err_pulse <= 1'b1;
                        r_err_code  <= {~r_range_ok, ~r_sel_ok};
                    end
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Each bank owns its registers; only the one-hot selected bank loads on commit.
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_bank
        logic [FIELD_W-1:0] r_bank_less;
        logic [FIELD_W-1:0] r_bank_middle;
        logic [FIELD_W-1:0] r_bank_big;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_bank_less   <= '0;
                r_bank_middle <= '0;
                r_bank_big    <= '0;
            end else if (w_commit && r_sel[gi]) begin
                r_bank_less   <= r_less;
                r_bank_middle <= r_middle;
                r_bank_big    <= r_big;
            end
        end

        assign bank_less[gi*FIELD_W +: FIELD_W]   = r_bank_less;
        assign bank_middle[gi*FIELD_W +: FIELD_W] = r_bank_middle;
        assign bank_big[gi*FIELD_W +: FIELD_W]    = r_bank_big;
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign load_pulse = r_load;
    assign err_pulse  = r_err_pulse;
    assign err_code   = r_err_code;

endmodule
